// File: rtl/result_display_pkg.sv
// Shared constants for the result display path.
//   - FSM state encodings used by the binary-to-BCD engine.
//   - Active-low 7-segment codes {g,f,e,d,c,b,a} for digits 0..9, plus all-off.
package result_display_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam logic [6:0] SEG_0   = 7'b1000000;
  localparam logic [6:0] SEG_1   = 7'b1111001;
  localparam logic [6:0] SEG_2   = 7'b0100100;
  localparam logic [6:0] SEG_3   = 7'b0110000;
  localparam logic [6:0] SEG_4   = 7'b0011001;
  localparam logic [6:0] SEG_5   = 7'b0010010;
  localparam logic [6:0] SEG_6   = 7'b0000010;
  localparam logic [6:0] SEG_7   = 7'b1111000;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0010000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

endpackage

// File: rtl/result_display_bin2bcd12.sv
// bin2bcd12: sequential 12-bit binary to 4-digit BCD converter (shift-add-3).
//   clk, rst  : clock, async active-high reset
//   load      : capture strobe, accepted only when idle
//   value     : 12-bit unsigned input
//   busy      : high from the capture edge until the commit edge
//   done      : one-cycle pulse when bcd_out is updated
//   bcd_out   : {thousands, hundreds, tens, ones}
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | waiting for load; bcd_out holds the last result
// ST_CONVERT | 12 add-3/shift iterations, one per clock
// ST_COMMIT  | copy accumulator to bcd_out, pulse done
module bin2bcd12
  import result_display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out
);

  logic [1:0]  state;
  logic [11:0] bin;
  logic [15:0] acc;
  logic [3:0]  cnt;
  logic [15:0] acc_adj;
  logic [27:0] sr_next;

  // Correct every nibble before the shift so no digit can exceed 9 afterwards.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) acc_adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  assign sr_next = {acc_adj, bin} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bin     <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            bin   <= value;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          acc <= sr_next[27:12];
          bin <= sr_next[11:0];
          cnt <= cnt + 4'd1;
          if (cnt == 4'd11) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          bcd_out <= acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/result_display.sv
// result_display: captures a 12-bit result, converts it to BCD and scans it
// onto a 4-digit multiplexed active-low 7-segment display.
//   clk, rst  : clock, async active-high reset
//   load      : capture strobe for value
//   value     : 12-bit unsigned result word
//   busy/done : conversion handshake from the BCD engine
//   bcd_out   : last committed BCD result
//   an        : active-low digit enables, an[0] = ones digit
//   seg       : active-low segments {g,f,e,d,c,b,a}
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [11:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd_out,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    scan_idx;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_OFF;
    endcase
  endfunction

  bin2bcd12 u_bin2bcd12 (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  always_comb begin
    nib = bcd_out[scan_idx*4 +: 4];
  end

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    blank = 1'b0;
    case (scan_idx)
      2'd1:    blank = (bcd_out[15:4]  == 12'd0);
      2'd2:    blank = (bcd_out[15:8]  == 8'd0);
      2'd3:    blank = (bcd_out[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
    blank = blank & BLANK_LZ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
    end else begin
      an  <= ~(4'b0001 << scan_idx);
      seg <= blank ? SEG_OFF : seg_decode(nib);
    end
  end

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [11:0] value = '0;
  logic        busy, done;
  logic [15:0] bcd_out;
  logic [3:0]  an;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_err = 0;

  result_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .busy(busy), .done(done), .bcd_out(bcd_out), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by plain arithmetic.
  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: ref_seg = 7'b1000000;  1: ref_seg = 7'b1111001;
      2: ref_seg = 7'b0100100;  3: ref_seg = 7'b0110000;
      4: ref_seg = 7'b0011001;  5: ref_seg = 7'b0010010;
      6: ref_seg = 7'b0000010;  7: ref_seg = 7'b1111000;
      8: ref_seg = 7'b0000000;  9: ref_seg = 7'b0010000;
      default: ref_seg = 7'b1111111;
    endcase
  endfunction

  // Expected pattern on digit position idx for a displayed decimal number.
  function automatic logic [6:0] ref_digit_seg(input int num, input int idx);
    int p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (idx > 0 && num < p) ref_digit_seg = 7'b1111111;
    else ref_digit_seg = ref_seg((num / p) % 10);
  endfunction

  // Called at a negedge. Loads v, checks busy/done timing and the result.
  // If intf_at >= 0, a competing load of intf_v is driven at that cycle.
  task automatic load_and_check(input int v, input int intf_at, input int intf_v, input int exp_num);
    load = 1'b1; value = 12'(v);
    @(negedge clk);
    load = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL start v=%0d: busy=%b done=%b, required busy=1 done=0", v, busy, done);
    end
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (k < 13) begin
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          n_err++; $display("FAIL busy v=%0d cycle %0d: busy=%b done=%b, required busy=1 done=0", v, k, busy, done);
        end
        if (k == intf_at) begin load = 1'b1; value = 12'(intf_v); end
      end else begin
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          n_err++; $display("FAIL done v=%0d: done=%b busy=%b, required done=1 busy=0", v, done, busy);
        end
        n_cmp++;
        if (bcd_out !== ref_bcd(exp_num)) begin
          n_err++; $display("FAIL bcd v=%0d: bcd_out=%h, required %h", v, bcd_out, ref_bcd(exp_num));
        end
      end
    end
  endtask

  // Observes 16 scan cycles and checks seg against the expected digit for whatever an selects.
  task automatic check_display(input int num);
    logic [3:0] seen = '0;
    int idx;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      n_cmp++;
      if (idx < 0) begin
        n_err++; $display("FAIL an_onehot num=%0d: an=%b, required one-hot-low", num, an);
      end else begin
        seen[idx] = 1'b1;
        if (seg !== ref_digit_seg(num, idx)) begin
          n_err++; $display("FAIL seg num=%0d digit %0d: seg=%b, required %b", num, idx, seg, ref_digit_seg(num, idx));
        end
      end
    end
    n_cmp++;
    if (seen !== 4'b1111) begin
      n_err++; $display("FAIL scan_cover num=%0d: digits seen=%b, required 1111", num, seen);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0000) begin
      n_err++; $display("FAIL reset: an=%b seg=%b busy=%b done=%b bcd=%h, required 1111 1111111 0 0 0000", an, seg, busy, done, bcd_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_max();
    load_and_check(4095, -1, 0, 4095);
    check_display(4095);
  endtask

  task automatic test_blank_small();
    @(negedge clk);
    load_and_check(7, -1, 0, 7);
    check_display(7);
  endtask

  task automatic test_ignore_busy_load();
    @(negedge clk);
    load_and_check(100, 5, 999, 100);
    n_cmp++;
    @(negedge clk);
    if (busy !== 1'b0 || bcd_out !== 16'h0100) begin
      n_err++; $display("FAIL ignored_load: busy=%b bcd=%h, required busy=0 bcd=0100", busy, bcd_out);
    end
    load_and_check(999, -1, 0, 999);
    check_display(999);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    load_and_check(321, -1, 0, 321);
    load_and_check(58, -1, 0, 58);
    check_display(58);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clk);
    load = 1'b1; value = 12'd2048;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bcd_out !== 16'h0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort: bcd=%h busy=%b, required 0000 0", bcd_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || bcd_out !== 16'h0000) begin
      n_err++; $display("FAIL abort_nodone: done pulses=%0d bcd=%h, required 0 0000", pulses, bcd_out);
    end
    load_and_check(0, -1, 0, 0);
    check_display(0);
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    int run = 0;
    int changes = 0;
    @(negedge clk);
    load_and_check(1234, -1, 0, 1234);
    @(negedge clk);
    prev = an;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (an !== prev) begin
        if (changes > 0) begin
          n_cmp++;
          if (run != 4) begin
            n_err++; $display("FAIL scan_hold an=%b: held %0d cycles, required 4", prev, run);
          end
        end
        n_cmp++;
        if (an !== {prev[2:0], prev[3]}) begin
          n_err++; $display("FAIL scan_order: an=%b after %b, required %b", an, prev, {prev[2:0], prev[3]});
        end
        changes++;
        run = 1;
        prev = an;
      end else begin
        run++;
      end
    end
    n_cmp++;
    if (changes < 8) begin
      n_err++; $display("FAIL scan_activity: %0d an changes, required >= 8", changes);
    end
    check_display(1234);
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(4095, 0));
      @(negedge clk);
      load_and_check(v, -1, 0, v);
      check_display(v);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blank_small();
    test_ignore_busy_load();
    test_back_to_back();
    test_reset_abort();
    test_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Consumer end of the calculator result path: takes the 12-bit result word produced by the operation selector and drives a 4-digit multiplexed 7-segment display.
- Captures the value on a load strobe and converts it to 4 BCD digits with a sequential shift-add-3 engine.
- Scans the digits continuously, with optional leading-zero blanking.
- Sits between the result selector and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit (50 MHz gives 1 kHz per digit).
- BLANK_LZ, 1, 1 = blank leading zeros on digits 3..1 (digit 0 is never blanked).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  capture strobe, sampled on clk.
- value  input  12  unsigned result word, 0..4095.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out is updated.
- bcd_out  output  16  {thousands, hundreds, tens, ones}, 4 bits each.
- an  output  4  digit enables, active-low; an[0] is the ones digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset is asynchronous and active-high; one clock domain (clk).
- Reset values:
  - busy=0, done=0, bcd_out=16'h0000.
  - an=4'b1111, seg=7'b1111111.
  - FSM=IDLE, shift count=0, scan index=0, refresh counter=0.
- FSM state IDLE:
  - load=1 at edge N: value goes into a 12-bit binary shift register, the 16-bit BCD accumulator clears, count=0.
  - Next state is CONVERT; busy=1 from edge N.
- FSM state CONVERT:
  - On each edge, every BCD nibble >=5 gets +3, then the {bcd,bin} 28-bit register shifts left by 1 and count increments.
  - After the 12th shift (edge N+12) the FSM moves to COMMIT.
- FSM state COMMIT:
  - Edge N+13: bcd_out is loaded from the accumulator, done=1 for exactly one cycle, busy=0.
  - Next state is IDLE.
- Timing and ordering:
  - Latency from load to done is 13 cycles. Back-to-back loads are accepted from the cycle after done.
  - load while busy=1 (CONVERT or COMMIT) is ignored; the in-flight conversion is unaffected.
- Widths:
  - No overflow is possible: 4095 fits in 4 digits.
  - The add-3 correction is applied before the shift on every iteration, including the first.
- Reset mid-conversion aborts immediately: bcd_out returns to 0 and no done pulse is produced.
- Refresh scan:
  - The refresh counter counts 0..REFRESH_DIV-1 freely, independent of the FSM.
  - At the terminal count it wraps to 0 and the scan index advances 0→1→2→3→0.
  - an is the one-hot-low of the index (index 0 gives 4'b1110). an and seg are registered and change on the same edge.
  - seg shows the bcd_out nibble selected by the index.
  - The display keeps showing the previous bcd_out during conversion and updates only at COMMIT.
- Segment codes, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibbles 10..15 cannot occur; they decode to all-off.
- Blanking:
  - With BLANK_LZ=1, digit i>0 is blanked (seg=1111111, an still asserted) when the digits i..3 are all zero.
  - Value 0 therefore shows a single "0".

Decomposition:
- Shared include file holds the FSM state encodings (IDLE, CONVERT, COMMIT) and the 10 segment code constants, for reuse by other display blocks.
- Sub-module bin2bcd12 holds the IDLE/CONVERT/COMMIT engine with its load/busy/done/bcd_out handshake.
- The top level holds the refresh counter, scan index, blanking logic and segment decoder function.

Test Plan:
- REFRESH_DIV=4 for simulation in all tests.
- Reset: rst pulse asynchronous to clk → an=1111, seg=1111111, busy=0, bcd_out=0 immediately, before the next edge.
- Load value=12'd4095 → busy on cycles 1..12, done pulse at cycle 13, bcd_out=16'h4095. Scanned seg per index 0..3 = 0010010, 0010000, 1000000, 0011001.
- Load value=12'd7 with BLANK_LZ=1 → bcd_out=16'h0007. Digit 0 seg=1111000; digits 1..3 seg=1111111 with an still asserting each in turn.
- Load 12'd100, then a second load of 12'd999 at cycle 5 → second load ignored, bcd_out=16'h0100. A fresh load after done gives 16'h0999.
- Load 12'd2048, assert rst at cycle 6 → no done pulse, bcd_out=0. After release, load 12'd0 gives bcd_out=0 and only digit 0 shows 1000000.
- Scan check: hold 16'h1234 → an sequence 1110, 1101, 1011, 0111, each held 4 cycles, then wraps.
